reg_file_access_arbiter: RTL and testbench

// - Shares one reg_file_memory instance between a software requester (SW, bus decode) and a hardware requester (HW, user logic).
// - Arbitrates requests, drives the memory port(s) and routes read data back to the issuing requester.
// - Sits between the bus slave / user datapath and reg_file_memory.

---
 rtl/reg_file_access_arbiter.sv | 179 +++++++++++++++++
 tb/tb_reg_file_access_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_access_arbiter.sv
// Shares one reg_file_memory between a SW and a HW requester.
// Grants requests, drives the memory ports and routes read data back to the owner.
package reg_file_pkg;
    typedef enum logic {
        REG_FILE_MEMORY_TYPE_SINGLE_PORT = 1'b0,
        REG_FILE_MEMORY_TYPE_DUAL_PORT   = 1'b1
    } reg_file_memory_type_e;
endpackage

module reg_file_access_arbiter
    import reg_file_pkg::*;
#(
    parameter reg_file_memory_type_e MEMORY_TYPE = REG_FILE_MEMORY_TYPE_DUAL_PORT,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sw_req_valid,
    output logic                    sw_req_ready,
    input  logic                    sw_req_we,
    input  logic [ADDR_WIDTH-1:0]   sw_req_addr,
    input  logic [DATA_WIDTH-1:0]   sw_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] sw_req_be,
    output logic                    sw_rsp_valid,
    output logic [DATA_WIDTH-1:0]   sw_rsp_rdata,
    input  logic                    hw_req_valid,
    output logic                    hw_req_ready,
    input  logic                    hw_req_we,
    input  logic [ADDR_WIDTH-1:0]   hw_req_addr,
    input  logic [DATA_WIDTH-1:0]   hw_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] hw_req_be,
    output logic                    hw_rsp_valid,
    output logic [DATA_WIDTH-1:0]   hw_rsp_rdata,
    output logic                    mem_a_en,
    output logic                    mem_a_we,
    output logic [ADDR_WIDTH-1:0]   mem_a_addr,
    output logic [DATA_WIDTH-1:0]   mem_a_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_a_be,
    input  logic [DATA_WIDTH-1:0]   mem_a_rdata,
    output logic                    mem_b_en,
    output logic                    mem_b_we,
    output logic [ADDR_WIDTH-1:0]   mem_b_addr,
    output logic [DATA_WIDTH-1:0]   mem_b_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_b_be,
    input  logic [DATA_WIDTH-1:0]   mem_b_rdata
);

    localparam int   BW    = DATA_WIDTH / 8;
    localparam bit   SP    = (MEMORY_TYPE == REG_FILE_MEMORY_TYPE_SINGLE_PORT);
    localparam logic ID_SW = 1'b0;
    localparam logic ID_HW = 1'b1;

    logic                  r_last_grant;
    logic                  r_hw_prio;
    logic [RD_LATENCY-1:0] r_a_v;
    logic [RD_LATENCY-1:0] r_a_id;
    logic [RD_LATENCY-1:0] r_b_v;
    logic [RD_LATENCY-1:0] r_b_id;

    logic w_collide;
    logic w_a_id;
    logic w_a_rd;
    logic w_b_rd;
    logic w_sw_a;
    logic w_sw_b;
    logic w_hw_a;
    logic w_hw_b;

    assign w_collide = sw_req_valid && hw_req_valid
                    && (sw_req_addr == hw_req_addr)
                    && (sw_req_we || hw_req_we);

    // Dual port: SW wins a collision unless HW lost the previous one
    always_comb begin
        sw_req_ready = 1'b0;
        hw_req_ready = 1'b0;
        if (!rst) begin
            if (SP) begin
                sw_req_ready = sw_req_valid
                            && (!hw_req_valid || r_last_grant == ID_HW);
                hw_req_ready = hw_req_valid
                            && (!sw_req_valid || r_last_grant == ID_SW);
            end else begin
                sw_req_ready = sw_req_valid && !(w_collide && r_hw_prio);
                hw_req_ready = hw_req_valid && !(w_collide && !r_hw_prio);
            end
        end
    end

    always_comb begin
        mem_a_en    = 1'b0;
        mem_a_we    = 1'b0;
        mem_a_addr  = '0;
        mem_a_wdata = '0;
        mem_a_be    = '0;
        mem_b_en    = 1'b0;
        mem_b_we    = 1'b0;
        mem_b_addr  = '0;
        mem_b_wdata = '0;
        mem_b_be    = '0;
        w_a_id      = ID_SW;
        if (sw_req_ready) begin
            mem_a_en    = 1'b1;
            mem_a_we    = sw_req_we;
            mem_a_addr  = sw_req_addr;
            mem_a_wdata = sw_req_wdata;
            mem_a_be    = sw_req_we ? sw_req_be : {BW{1'b0}};
        end else if (SP && hw_req_ready) begin
            mem_a_en    = 1'b1;
            mem_a_we    = hw_req_we;
            mem_a_addr  = hw_req_addr;
            mem_a_wdata = hw_req_wdata;
            mem_a_be    = hw_req_we ? hw_req_be : {BW{1'b0}};
            w_a_id      = ID_HW;
        end
        if (!SP && hw_req_ready) begin
            mem_b_en    = 1'b1;
            mem_b_we    = hw_req_we;
            mem_b_addr  = hw_req_addr;
            mem_b_wdata = hw_req_wdata;
            mem_b_be    = hw_req_we ? hw_req_be : {BW{1'b0}};
        end
    end

    assign w_a_rd = mem_a_en && !mem_a_we;
    assign w_b_rd = mem_b_en && !mem_b_we;
    assign w_sw_a = r_a_v[RD_LATENCY-1] && (r_a_id[RD_LATENCY-1] == ID_SW);
    assign w_hw_a = r_a_v[RD_LATENCY-1] && (r_a_id[RD_LATENCY-1] == ID_HW);
    assign w_sw_b = r_b_v[RD_LATENCY-1] && (r_b_id[RD_LATENCY-1] == ID_SW);
    assign w_hw_b = r_b_v[RD_LATENCY-1] && (r_b_id[RD_LATENCY-1] == ID_HW);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= ID_HW;
            r_hw_prio    <= 1'b0;
            r_a_v        <= '0;
            r_a_id       <= '0;
            r_b_v        <= '0;
            r_b_id       <= '0;
            sw_rsp_valid <= 1'b0;
            sw_rsp_rdata <= '0;
            hw_rsp_valid <= 1'b0;
            hw_rsp_rdata <= '0;
        end else begin
            if (sw_req_ready) begin
                r_last_grant <= ID_SW;
            end else if (hw_req_ready) begin
                r_last_grant <= ID_HW;
            end
            r_hw_prio <= w_collide && !r_hw_prio;
            // Tail of each shift register lines up with valid mem rdata
            r_a_v[0]  <= w_a_rd;
            r_a_id[0] <= w_a_id;
            r_b_v[0]  <= w_b_rd;
            r_b_id[0] <= ID_HW;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_a_v[i]  <= r_a_v[i-1];
                r_a_id[i] <= r_a_id[i-1];
                r_b_v[i]  <= r_b_v[i-1];
                r_b_id[i] <= r_b_id[i-1];
            end
            sw_rsp_valid <= w_sw_a || w_sw_b;
            hw_rsp_valid <= w_hw_a || w_hw_b;
            if (w_sw_a) begin
                sw_rsp_rdata <= mem_a_rdata;
            end else if (w_sw_b) begin
                sw_rsp_rdata <= mem_b_rdata;
            end
            if (w_hw_a) begin
                hw_rsp_rdata <= mem_a_rdata;
            end else if (w_hw_b) begin
                hw_rsp_rdata <= mem_b_rdata;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_access_arbiter.sv
// Randomised scoreboard bench for reg_file_access_arbiter.
// Instance 0: single port, latency 1; 1: dual port, latency 3; 2: dual port, latency 2.
module tb_reg_file_access_arbiter;

    localparam int N  = 3;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int BW = 4;

    typedef struct packed {
        logic [31:0] d;
        logic [31:0] t;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst   [N];
    logic          q_v   [N][2];
    logic          q_we  [N][2];
    logic [AW-1:0] q_ad  [N][2];
    logic [DW-1:0] q_wd  [N][2];
    logic [BW-1:0] q_be  [N][2];
    logic          q_rdy [N][2];
    logic          p_v   [N][2];
    logic [DW-1:0] p_d   [N][2];
    logic          m_en  [N][2];
    logic          m_we  [N][2];
    logic [AW-1:0] m_ad  [N][2];
    logic [DW-1:0] m_wd  [N][2];
    logic [BW-1:0] m_be  [N][2];
    logic [DW-1:0] m_rd  [N][2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    exp_t          sb      [2*N][$];
    logic [DW-1:0] ref_mem [N][256];
    logic          lg      [N];
    logic          prio    [N];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_val(int g, int a);
        return (32'(a) * 32'h9E37_79B1) ^ (32'(g) << 28);
    endfunction

    function automatic int lat(int g);
        return (g == 0) ? 1 : ((g == 1) ? 3 : 2);
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_inst
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 2);
        localparam reg_file_pkg::reg_file_memory_type_e MT = (g == 0)
            ? reg_file_pkg::REG_FILE_MEMORY_TYPE_SINGLE_PORT
            : reg_file_pkg::REG_FILE_MEMORY_TYPE_DUAL_PORT;

        reg_file_access_arbiter #(
            .MEMORY_TYPE (MT),
            .ADDR_WIDTH  (AW),
            .DATA_WIDTH  (DW),
            .RD_LATENCY  (L)
        ) u_dut (
            .clk          (clk),
            .rst          (rst[g]),
            .sw_req_valid (q_v[g][0]),
            .sw_req_ready (q_rdy[g][0]),
            .sw_req_we    (q_we[g][0]),
            .sw_req_addr  (q_ad[g][0]),
            .sw_req_wdata (q_wd[g][0]),
            .sw_req_be    (q_be[g][0]),
            .sw_rsp_valid (p_v[g][0]),
            .sw_rsp_rdata (p_d[g][0]),
            .hw_req_valid (q_v[g][1]),
            .hw_req_ready (q_rdy[g][1]),
            .hw_req_we    (q_we[g][1]),
            .hw_req_addr  (q_ad[g][1]),
            .hw_req_wdata (q_wd[g][1]),
            .hw_req_be    (q_be[g][1]),
            .hw_rsp_valid (p_v[g][1]),
            .hw_rsp_rdata (p_d[g][1]),
            .mem_a_en     (m_en[g][0]),
            .mem_a_we     (m_we[g][0]),
            .mem_a_addr   (m_ad[g][0]),
            .mem_a_wdata  (m_wd[g][0]),
            .mem_a_be     (m_be[g][0]),
            .mem_a_rdata  (m_rd[g][0]),
            .mem_b_en     (m_en[g][1]),
            .mem_b_we     (m_we[g][1]),
            .mem_b_addr   (m_ad[g][1]),
            .mem_b_wdata  (m_wd[g][1]),
            .mem_b_be     (m_be[g][1]),
            .mem_b_rdata  (m_rd[g][1])
        );

        // Write-first memory with an L-cycle read pipeline
        logic [DW-1:0] mem  [256];
        logic [DW-1:0] pipe [2][4];

        initial begin
            for (int i = 0; i < 256; i++) mem[i] = init_val(g, i);
        end

        always @(posedge clk) begin
            for (int p = 0; p < 2; p++) begin
                if (m_en[g][p] && m_we[g][p]) begin
                    for (int b = 0; b < BW; b++) begin
                        if (m_be[g][p][b]) mem[m_ad[g][p]][8*b +: 8] = m_wd[g][p][8*b +: 8];
                    end
                end
            end
            for (int p = 0; p < 2; p++) begin
                pipe[p][0] <= (m_en[g][p] && !m_we[g][p]) ? mem[m_ad[g][p]] : 32'hBAD0_BAD0;
                for (int k = 1; k < 4; k++) pipe[p][k] <= pipe[p][k-1];
            end
        end

        assign m_rd[g][0] = pipe[0][L-1];
        assign m_rd[g][1] = pipe[1][L-1];
    end

    // Monitor: every response must match the oldest outstanding read of its owner
    always @(negedge clk) begin
        exp_t e;
        for (int g = 0; g < N; g++) begin
            for (int r = 0; r < 2; r++) begin
                if (p_v[g][r] === 1'b1) begin
                    total++;
                    if (sb[2*g+r].size() == 0) begin
                        bad++;
                        $display("FAIL rsp_unexpected g%0d r%0d cyc%0d: got data %h, want no response",
                                 g, r, cyc, p_d[g][r]);
                    end else begin
                        e = sb[2*g+r].pop_front();
                        if (p_d[g][r] !== e.d || cyc != int'(e.t)) begin
                            bad++;
                            $display("FAIL rsp_data g%0d r%0d: got %h at cyc %0d, want %h at cyc %0d",
                                     g, r, p_d[g][r], cyc, e.d, e.t);
                        end
                    end
                end
            end
        end
        total++;
        if (m_en[0][1] !== 1'b0) begin
            bad++;
            $display("FAIL sp_port_b_idle cyc%0d: got en %b, want 0", cyc, m_en[0][1]);
        end
    end

    task automatic put(int g, int r, bit we, logic [AW-1:0] a, logic [DW-1:0] d, logic [BW-1:0] be);
        q_v[g][r]  = 1'b1;
        q_we[g][r] = we;
        q_ad[g][r] = a;
        q_wd[g][r] = d;
        q_be[g][r] = be;
    endtask

    // One cycle: predict grants from the arbitration rules, check ready, update the reference
    task automatic step();
        bit acc [N][2];
        bit vs, vh, clash;
        logic [AW-1:0] a;
        #1;
        for (int g = 0; g < N; g++) begin
            vs = q_v[g][0];
            vh = q_v[g][1];
            clash = vs && vh && (q_ad[g][0] == q_ad[g][1]) && (q_we[g][0] || q_we[g][1]);
            acc[g][0] = 1'b0;
            acc[g][1] = 1'b0;
            if (!rst[g]) begin
                if (g == 0) begin
                    if (vs && vh) begin
                        acc[g][0] = lg[g];
                        acc[g][1] = !lg[g];
                    end else begin
                        acc[g][0] = vs;
                        acc[g][1] = vh;
                    end
                end else begin
                    acc[g][0] = vs && !(clash && prio[g]);
                    acc[g][1] = vh && !(clash && !prio[g]);
                end
            end
            for (int r = 0; r < 2; r++) begin
                total++;
                if (q_rdy[g][r] !== acc[g][r]) begin
                    bad++;
                    $display("FAIL ready g%0d r%0d cyc%0d: got %b, want %b",
                             g, r, cyc, q_rdy[g][r], acc[g][r]);
                end
                if (acc[g][r]) begin
                    a = q_ad[g][r];
                    if (q_we[g][r]) begin
                        for (int b = 0; b < BW; b++) begin
                            if (q_be[g][r][b]) ref_mem[g][a][8*b +: 8] = q_wd[g][r][8*b +: 8];
                        end
                    end else begin
                        sb[2*g+r].push_back({ref_mem[g][a], 32'(cyc + lat(g) + 1)});
                    end
                end
            end
            if (!rst[g]) begin
                if (acc[g][0]) lg[g] = 1'b0;
                else if (acc[g][1]) lg[g] = 1'b1;
                prio[g] = clash && !prio[g];
            end
        end
        @(posedge clk);
        #1;
        for (int g = 0; g < N; g++) begin
            for (int r = 0; r < 2; r++) begin
                if (acc[g][r]) q_v[g][r] = 1'b0;
            end
        end
    endtask

    task automatic drain();
        bit busy;
        for (int k = 0; k < 40; k++) begin
            busy = 1'b0;
            for (int g = 0; g < N; g++) begin
                for (int r = 0; r < 2; r++) busy |= q_v[g][r];
            end
            if (!busy) return;
            step();
        end
        total++;
        bad++;
        $display("FAIL drain_timeout cyc%0d: requests still pending, want none", cyc);
    endtask

    task automatic chk_reset(int g);
        for (int r = 0; r < 2; r++) begin
            total++;
            if (p_v[g][r] !== 1'b0 || p_d[g][r] !== '0 || q_rdy[g][r] !== 1'b0 ||
                m_en[g][r] !== 1'b0 || m_we[g][r] !== 1'b0 || m_ad[g][r] !== '0 ||
                m_wd[g][r] !== '0 || m_be[g][r] !== '0) begin
                bad++;
                $display("FAIL reset_outputs g%0d r%0d: got rv=%b rd=%h rdy=%b en=%b we=%b, want all 0",
                         g, r, p_v[g][r], p_d[g][r], q_rdy[g][r], m_en[g][r], m_we[g][r]);
            end
        end
    endtask

    task automatic reset_model(int g);
        lg[g]   = 1'b1;
        prio[g] = 1'b0;
        sb[2*g].delete();
        sb[2*g+1].delete();
    endtask

    initial begin
        for (int g = 0; g < N; g++) begin
            rst[g] = 1'b1;
            reset_model(g);
            for (int i = 0; i < 256; i++) ref_mem[g][i] = init_val(g, i);
            for (int r = 0; r < 2; r++) begin
                q_v[g][r]  = 1'b0;
                q_we[g][r] = 1'b0;
                q_ad[g][r] = '0;
                q_wd[g][r] = '0;
                q_be[g][r] = '0;
            end
        end
        @(posedge clk);
        #1;
        step();
        step();
        for (int g = 0; g < N; g++) chk_reset(g);
        for (int g = 0; g < N; g++) rst[g] = 1'b0;

        // Single port round-robin with both requesters always valid
        for (int c = 0; c < 6; c++) begin
            for (int r = 0; r < 2; r++) begin
                if (!q_v[0][r]) put(0, r, 1'b0, 8'(8'h40 + 8'(2 * c + r)), '0, '0);
            end
            step();
        end
        drain();

        put(0, 0, 1'b1, 8'h10, 32'hDEAD_BEEF, 4'hF);
        drain();
        put(0, 0, 1'b0, 8'h10, '0, '0);
        drain();

        put(0, 1, 1'b1, 8'h20, 32'hFFFF_FFFF, 4'hF);
        drain();
        put(0, 1, 1'b1, 8'h20, 32'h0000_0000, 4'b0101);
        drain();
        put(0, 1, 1'b0, 8'h20, '0, '0);
        drain();

        // Dual port collision: SW write and HW read to the same word
        for (int g = 1; g < N; g++) begin
            put(g, 0, 1'b1, 8'h05, 32'h1234_5678, 4'hF);
            put(g, 1, 1'b0, 8'h05, '0, '0);
        end
        step();
        step();
        drain();

        // Dual port full throughput
        for (int c = 0; c < 8; c++) begin
            put(1, 0, 1'b0, 8'(c), '0, '0);
            put(1, 1, 1'b0, 8'(8'h80 + 8'(c)), '0, '0);
            step();
        end
        drain();
        repeat (6) step();

        // Reset one cycle after a read is accepted
        put(2, 0, 1'b0, 8'h33, '0, '0);
        step();
        rst[2] = 1'b1;
        reset_model(2);
        put(2, 1, 1'b0, 8'h44, '0, '0);
        step();
        step();
        chk_reset(2);
        rst[2] = 1'b0;
        drain();

        for (int c = 0; c < 600; c++) begin
            for (int g = 0; g < N; g++) begin
                for (int r = 0; r < 2; r++) begin
                    if (!q_v[g][r] && $urandom_range(1, 0) == 1)
                        put(g, r, 1'($urandom_range(1, 0)), 8'($urandom_range(7, 0)),
                            $urandom, 4'($urandom_range(15, 0)));
                end
            end
            step();
        end
        drain();
        repeat (8) step();

        for (int i = 0; i < 2 * N; i++) begin
            total++;
            if (sb[i].size() != 0) begin
                bad++;
                $display("FAIL rsp_missing slot%0d: got %0d reads unanswered, want 0", i, sb[i].size());
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
